// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding read to instruction memory feeding a
// 2-entry {word, pc} FIFO toward execute, with redirect flush and halt-opcode stop.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] instruction,
    output logic [31:0] ins_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    // state | meaning
    // IDLE  | no request outstanding
    // REQ   | request outstanding, response will be pushed
    // DRAIN | request outstanding, response will be discarded (after redirect)
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_mem_addr;
    logic        r_mem_req;
    logic        r_halted;
    logic [31:0] r_word [2];
    logic [31:0] r_wpc  [2];
    logic        r_head;
    logic [1:0]  r_count;

    logic        w_pop;
    logic        w_push;
    logic [1:0]  w_count_next;
    logic        w_tail;
    logic        w_halt_word;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_next_addr;

    // Redirect wins over both a same-cycle pop and a same-cycle push.
    assign w_pop         = (r_count != 2'd0) && ins_ready && !redirect;
    assign w_push        = (r_state == REQ) && mem_ack && !redirect;
    assign w_count_next  = r_count + {1'b0, w_push} - {1'b0, w_pop};
    assign w_tail        = r_head ^ r_count[0];
    assign w_halt_word   = (mem_rdata[5:0] == HALT_OPCODE);
    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_next_addr   = r_mem_addr + 32'd4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC_ALIGNED;
            r_mem_addr <= '0;
            r_mem_req  <= 1'b0;
            r_halted   <= 1'b0;
            r_head     <= 1'b0;
            r_count    <= '0;
            for (int i = 0; i < 2; i++) begin
                r_word[i] <= '0;
                r_wpc[i]  <= '0;
            end
        end else begin
            if (w_pop)
                r_head <= ~r_head;
            if (w_push) begin
                r_word[w_tail] <= mem_rdata;
                r_wpc[w_tail]  <= r_mem_addr;
            end
            r_count <= w_count_next;

            if (redirect) begin
                r_count  <= '0;
                r_head   <= 1'b0;
                r_pc     <= w_redirect_pc;
                r_halted <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (redirect) begin
                        r_state    <= REQ;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_redirect_pc;
                    end else if ((w_count_next < 2'd2) && !r_halted) begin
                        r_state    <= REQ;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_pc;
                    end
                end
                REQ: begin
                    if (redirect && mem_ack) begin
                        r_mem_addr <= w_redirect_pc;
                    end else if (redirect) begin
                        r_state <= DRAIN;
                    end else if (mem_ack) begin
                        r_pc <= w_next_addr;
                        if (w_halt_word) begin
                            r_halted  <= 1'b1;
                            r_state   <= IDLE;
                            r_mem_req <= 1'b0;
                        end else if (w_count_next < 2'd2) begin
                            r_mem_addr <= w_next_addr;
                        end else begin
                            r_state   <= IDLE;
                            r_mem_req <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // The stale response is dropped; refetch from the newest target.
                    if (mem_ack) begin
                        r_state    <= REQ;
                        r_mem_addr <= redirect ? w_redirect_pc : r_pc;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign ins_valid   = (r_count != 2'd0);
    assign instruction = r_word[r_head];
    assign ins_pc      = r_wpc[r_head];
    assign halted      = r_halted;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, sets the first fetch address after reset; bits [1:0] SHALL be ignored (treated as 0).
REQ-002 Parameter HALT_OPCODE, default 6'h3F, sets the opcode value in instruction bits [5:0] that stops fetching.
REQ-003 Reset is rst, asynchronous, active-low; the clock is clk.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 mem_req  output  1  instruction memory read request, registered.
REQ-007 mem_addr  output  32  word-aligned read address, registered, bits [1:0] always 0.
REQ-008 mem_ack  input  1  memory response; mem_rdata is valid in the same cycle.
REQ-009 mem_rdata  input  32  instruction word read from memory.
REQ-010 ins_valid  output  1  instruction available to the execute stage.
REQ-011 ins_ready  input  1  execute stage accepts the instruction.
REQ-012 instruction  output  32  instruction word, fields: opcode[5:0] rs[10:6] rt[15:11] rd[20:16] shamt[25:21] func[31:26].
REQ-013 ins_pc  output  32  address the instruction was fetched from.
REQ-014 redirect  input  1  single-cycle flush-and-jump strobe.
REQ-015 redirect_pc  input  32  jump target; bits [1:0] forced to 0.
REQ-016 halted  output  1  high while fetching is stopped by HALT_OPCODE.

Function
REQ-017 The block SHALL hold a 2-entry FIFO of {word, pc} pairs, with ins_valid = (count != 0) and instruction/ins_pc driven from the head entry.
REQ-018 A transfer occurs when ins_valid && ins_ready, and SHALL pop the head entry at that clock edge.
REQ-019 A memory request is outstanding while mem_req=1; mem_addr SHALL remain stable until the cycle in which mem_ack=1.
REQ-020 At most one request SHALL be outstanding, and a request SHALL be issued only if count + 1 <= 2 with the pushed word included.
REQ-021 The FSM SHALL have three states: IDLE (no request), REQ (mem_req=1), and DRAIN (mem_req=1, response to be discarded).
REQ-022 IDLE->REQ occurs when count_next < 2, halted=0, and redirect=0; mem_addr is then set to the current pc.
REQ-023 REQ with mem_ack: push {mem_rdata, mem_addr}, set pc <= mem_addr+4 (modulo 2^32), and stay in REQ with mem_addr=pc+4 if count_next < 2; otherwise go to IDLE, where count_next = count + 1 - pop.
REQ-024 Throughput: with single-cycle ack and ins_ready=1, the block SHALL sustain one instruction per cycle; ins_valid SHALL rise 1 cycle after the first mem_ack.
REQ-025 If a pushed word has bits [5:0]==HALT_OPCODE, the word SHALL still be delivered, halted<=1, and the FSM SHALL go to IDLE with no further requests.
REQ-026 Redirect in IDLE: flush the FIFO (count<=0), set pc<=redirect_pc, clear halted, and issue the next request in the following cycle.
REQ-027 Redirect in REQ without mem_ack: flush, set pc<=redirect_pc, and enter DRAIN.
REQ-028 Redirect in REQ with mem_ack in the same cycle: discard the acked word, flush, and enter REQ with mem_addr=redirect_pc.
REQ-029 In DRAIN, mem_ack SHALL be consumed without a push, then go to REQ with mem_addr=pc; redirect in DRAIN SHALL update pc and remain in DRAIN, or leave DRAIN if mem_ack arrives in the same cycle.
REQ-030 Redirect SHALL take priority over a same-cycle pop; no transfer is counted in that cycle, so ins_valid is ignored by the consumer.
REQ-031 The FIFO SHALL never overflow or underflow; a push and a pop in the same cycle leave count unchanged.

Reset
REQ-032 On rst=0, at any time including mid-request, the block SHALL set state=IDLE, count=0, pc=RESET_PC, mem_req=0, mem_addr=0, ins_valid=0, instruction=0, ins_pc=0, and halted=0.
REQ-033 A response arriving after reset release for a request issued before reset SHALL NOT occur by system contract; the block need not handle it.
REQ-034 mem_req SHALL first assert in the cycle after rst deasserts.

Verification
REQ-035 Zero-wait memory, ins_ready=1, memory[a]=a: mem_addr SHALL be 0,4,8,… on consecutive cycles, and instruction/ins_pc SHALL equal 0,4,8,… one cycle later with no bubbles.
REQ-036 ins_ready=0 for 10 cycles: count SHALL reach 2, mem_req SHALL drop, and head instruction SHALL stay at pc 0; when ins_ready returns to 1, delivery resumes in order 0,4,8.
REQ-037 Ack delayed 3 cycles plus redirect to 32'h100 while waiting: the late word SHALL be discarded, the next mem_addr SHALL be 32'h100, and the first delivered ins_pc SHALL be 32'h100.
REQ-038 Redirect to 32'h203 together with mem_ack: the acked word SHALL be dropped, mem_addr SHALL be 32'h200 on the next cycle, and the FIFO SHALL be empty.
REQ-039 Word 32'h0000_003F at address 8: words at 0,4,8 SHALL be delivered, halted SHALL be 1, and there SHALL be no request to address 12; redirect to 0x40 SHALL clear halted and fetch 0x40.
REQ-040 Asserting rst during an outstanding request with a full FIFO: all outputs SHALL go to their reset values immediately (asynchronously); after release, the first mem_addr SHALL be RESET_PC.
